branch_predict_ctrl: RTL and testbench

- Fetch-side branch scheduler for the RV32I core. Predicts conditional branches from a direct-mapped table of 2-bit saturating counters.
- Compares each prediction against the resolved PCSrc from the execute-stage branch/jump decoder.
- Issues a registered redirect/flush to fetch on a mispredict and trains the table.
- Sits between the PC-select logic and the execute-stage branch/jump decode.

---
 rtl/branch_predict_ctrl.sv | 175 +++++++++++++++++
 tb/tb_branch_predict_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_ctrl.sv
// Fetch-side branch predictor: direct-mapped 2-bit saturating counters with a registered
// redirect/flush on mispredict. Optional performance counters under `BRPRED_PERF_EN`.
module branch_predict_ctrl #(
    parameter int IDX_BITS = 6,
    parameter int XLEN     = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            tbl_clear,
    input  logic            f_valid,
    input  logic [XLEN-1:0] f_pc,
    input  logic            f_is_branch,
    input  logic [XLEN-1:0] f_target,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic            ex_branch,
    input  logic            ex_jump,
    input  logic            ex_pcsrc,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush,
    output logic            init_done
`ifdef BRPRED_PERF_EN
    ,
    output logic [31:0]     perf_branches,
    output logic [31:0]     perf_mispredicts
`endif
);

    localparam int DEPTH = 1 << IDX_BITS;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                state_r;
    logic [IDX_BITS-1:0]   sweep_idx_r;
    logic [1:0]            ctr_r [DEPTH];
    logic                  redirect_r;
    logic                  flush_r;
    logic [XLEN-1:0]       redirect_pc_r;
    logic                  init_done_r;

    logic [IDX_BITS-1:0]   f_idx_s;
    logic [IDX_BITS-1:0]   ex_idx_s;
    logic                  pred_taken_s;
    logic [XLEN-1:0]       pred_target_s;
    logic                  mispredict_s;
    logic [XLEN-1:0]       fix_pc_s;
    logic                  train_s;
    logic [1:0]            cur_ctr_s;
    logic [1:0]            nxt_ctr_s;

    // Prediction lookup, mispredict detection and next counter value for training.
    always_comb begin
        f_idx_s      = f_pc[IDX_BITS+1:2];
        ex_idx_s     = ex_pc[IDX_BITS+1:2];
        pred_taken_s = (state_r == RUN) & f_valid & f_is_branch & ctr_r[f_idx_s][1];
        if (pred_taken_s) begin
            pred_target_s = f_target;
        end else begin
            pred_target_s = f_pc + XLEN'(32'd4);
        end
        mispredict_s = ex_valid & (ex_branch | ex_jump) & (ex_pcsrc != ex_pred_taken);
        if (ex_pcsrc) begin
            fix_pc_s = ex_target;
        end else begin
            fix_pc_s = ex_pc + XLEN'(32'd4);
        end
        train_s   = (state_r == RUN) & ex_valid & ex_branch & ~ex_jump;
        cur_ctr_s = ctr_r[ex_idx_s];
        if (ex_pcsrc) begin
            if (cur_ctr_s == 2'b11) begin
                nxt_ctr_s = cur_ctr_s;
            end else begin
                nxt_ctr_s = cur_ctr_s + 2'b01;
            end
        end else begin
            if (cur_ctr_s == 2'b00) begin
                nxt_ctr_s = cur_ctr_s;
            end else begin
                nxt_ctr_s = cur_ctr_s - 2'b01;
            end
        end
    end

    // Counter table: swept to weakly-not-taken during INIT, trained by resolved branches in RUN.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr_r[i] <= 2'b01;
            end
        end else if (state_r == INIT) begin
            ctr_r[sweep_idx_r] <= 2'b01;
        end else if (train_s) begin
            ctr_r[ex_idx_s] <= nxt_ctr_s;
        end
    end

    // Control FSM with registered redirect/flush; redirects fire in either state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= INIT;
            sweep_idx_r   <= '0;
            redirect_r    <= 1'b0;
            flush_r       <= 1'b0;
            redirect_pc_r <= '0;
            init_done_r   <= 1'b0;
        end else begin
            redirect_r <= mispredict_s;
            flush_r    <= mispredict_s;
            if (mispredict_s) begin
                redirect_pc_r <= fix_pc_s;
            end
            case (state_r)
                INIT: begin
                    sweep_idx_r <= sweep_idx_r + IDX_BITS'(1);
                    if (&sweep_idx_r) begin
                        state_r     <= RUN;
                        init_done_r <= 1'b1;
                    end
                end
                RUN: begin
                    if (tbl_clear) begin
                        state_r     <= INIT;
                        sweep_idx_r <= '0;
                        init_done_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= INIT;
                    sweep_idx_r <= '0;
                    init_done_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef BRPRED_PERF_EN
    logic [31:0] perf_branches_r;
    logic [31:0] perf_mispredicts_r;

    // Saturating event counters; untouched by tbl_clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_branches_r    <= 32'd0;
            perf_mispredicts_r <= 32'd0;
        end else begin
            if ((state_r == RUN) && ex_valid && (ex_branch || ex_jump)
                && (perf_branches_r != 32'hFFFF_FFFF)) begin
                perf_branches_r <= perf_branches_r + 32'd1;
            end
            if (mispredict_s && (perf_mispredicts_r != 32'hFFFF_FFFF)) begin
                perf_mispredicts_r <= perf_mispredicts_r + 32'd1;
            end
        end
    end

    assign perf_branches    = perf_branches_r;
    assign perf_mispredicts = perf_mispredicts_r;
`endif

    assign pred_taken  = pred_taken_s;
    assign pred_target = pred_target_s;
    assign redirect    = redirect_r;
    assign flush       = flush_r;
    assign redirect_pc = redirect_pc_r;
    assign init_done   = init_done_r;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Self-checking bench for branch_predict_ctrl: directed scenarios plus randomized traffic,
// checked every cycle against an integer-level behavioural model of the predictor.
module tb_branch_predict_ctrl;

    localparam int IDX_BITS = 6;
    localparam int XLEN     = 32;
    localparam int DEPTH    = 64;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            tbl_clear;
    logic            f_valid;
    logic [XLEN-1:0] f_pc;
    logic            f_is_branch;
    logic [XLEN-1:0] f_target;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            ex_valid;
    logic            ex_branch;
    logic            ex_jump;
    logic            ex_pcsrc;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_target;
    logic            ex_pred_taken;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            flush;
    logic            init_done;
`ifdef BRPRED_PERF_EN
    logic [31:0]     perf_branches;
    logic [31:0]     perf_mispredicts;
`endif

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    int          m_ctr [DEPTH];
    bit          m_init;
    int          m_sweep;
    bit          m_done;
    bit          m_redir;
    logic [31:0] m_rpc;
    longint      m_pb;
    longint      m_pm;

    branch_predict_ctrl #(.IDX_BITS(IDX_BITS), .XLEN(XLEN)) dut (
        .clk(clk), .reset_n(reset_n), .tbl_clear(tbl_clear),
        .f_valid(f_valid), .f_pc(f_pc), .f_is_branch(f_is_branch), .f_target(f_target),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_pcsrc(ex_pcsrc),
        .ex_pc(ex_pc), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
        .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush), .init_done(init_done)
`ifdef BRPRED_PERF_EN
        , .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % DEPTH);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_ctr[i] = 1;
        m_init = 1'b1; m_sweep = 0; m_done = 1'b0;
        m_redir = 1'b0; m_rpc = 32'd0; m_pb = 0; m_pm = 0;
    endtask

    // Advance the model by one clock using the currently applied inputs.
    task automatic model_step();
        bit mis;
        int ei;
        mis = ex_valid && (ex_branch || ex_jump) && (ex_pcsrc != ex_pred_taken);
        ei  = idx_of(ex_pc);
        if (!m_init && ex_valid && (ex_branch || ex_jump) && m_pb < 64'hFFFF_FFFF) m_pb++;
        if (mis && m_pm < 64'hFFFF_FFFF) m_pm++;
        m_redir = mis;
        if (mis) m_rpc = ex_pcsrc ? ex_target : ex_pc + 32'd4;
        if (m_init) begin
            m_ctr[m_sweep] = 1;
            if (m_sweep == DEPTH - 1) begin
                m_init = 1'b0; m_done = 1'b1; m_sweep = 0;
            end else begin
                m_sweep++;
            end
        end else begin
            if (ex_valid && ex_branch && !ex_jump) begin
                if (ex_pcsrc) m_ctr[ei] = (m_ctr[ei] >= 3) ? 3 : m_ctr[ei] + 1;
                else          m_ctr[ei] = (m_ctr[ei] <= 0) ? 0 : m_ctr[ei] - 1;
            end
            if (tbl_clear) begin
                m_init = 1'b1; m_sweep = 0; m_done = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        bit          ept;
        logic [31:0] etg;
        ept = !m_init && f_valid && f_is_branch && (m_ctr[idx_of(f_pc)] >= 2);
        etg = ept ? f_target : f_pc + 32'd4;
        check("pred_taken", {31'd0, pred_taken}, {31'd0, ept});
        check("pred_target", pred_target, etg);
        check("redirect", {31'd0, redirect}, {31'd0, m_redir});
        check("flush", {31'd0, flush}, {31'd0, m_redir});
        check("redirect_pc", redirect_pc, m_rpc);
        check("init_done", {31'd0, init_done}, {31'd0, m_done});
`ifdef BRPRED_PERF_EN
        check("perf_branches", perf_branches, m_pb[31:0]);
        check("perf_mispredicts", perf_mispredicts, m_pm[31:0]);
`endif
    endtask

    // One clock: compare on the falling edge, update the model on the rising edge.
    task automatic cycle();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        if (reset_n) model_step();
        #1;
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        model_reset();
        repeat (n) cycle();
        reset_n = 1'b1;
    endtask

    task automatic ex_idle();
        ex_valid = 1'b0; ex_branch = 1'b0; ex_jump = 1'b0;
        ex_pcsrc = 1'b0; ex_pred_taken = 1'b0;
    endtask

    task automatic train(input logic [31:0] pc, input bit taken, input int n);
        ex_valid = 1'b1; ex_branch = 1'b1; ex_jump = 1'b0;
        ex_pc = pc; ex_pcsrc = taken; ex_pred_taken = taken;
        repeat (n) cycle();
        ex_idle();
    endtask

    task automatic sweep_and_check(input string tag);
        repeat (63) cycle();
        check({tag, "_init_done_63"}, {31'd0, init_done}, 32'd0);
        cycle();
        check({tag, "_init_done_64"}, {31'd0, init_done}, 32'd1);
        f_valid = 1'b1; f_is_branch = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            f_pc = 32'h1000 + 32'(i * 4);
            #1;
            check({tag, "_all_not_taken"}, {31'd0, pred_taken}, 32'd0);
        end
    endtask

    initial begin
        reset_n = 1'b0; tbl_clear = 1'b0;
        f_valid = 1'b0; f_pc = 32'd0; f_is_branch = 1'b0; f_target = 32'd0;
        ex_pc = 32'd0; ex_target = 32'd0;
        ex_idle();
        do_reset(3);
        check("rst_init_done", {31'd0, init_done}, 32'd0);
        check("rst_redirect", {31'd0, redirect}, 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);
`ifdef BRPRED_PERF_EN
        check("rst_perf_br", perf_branches, 32'd0);
        check("rst_perf_mis", perf_mispredicts, 32'd0);
`endif

        // INIT sweep with a branch in fetch: never predicted taken.
        f_valid = 1'b1; f_is_branch = 1'b1; f_pc = 32'h100; f_target = 32'h140;
        repeat (63) cycle();
        check("init_done_63", {31'd0, init_done}, 32'd0);
        cycle();
        check("init_done_64", {31'd0, init_done}, 32'd1);

        // Train 0x100 up to strongly taken, then back to weakly not-taken.
        train(32'h100, 1'b1, 2);
        #1;
        check("trained_pred_taken", {31'd0, pred_taken}, 32'd1);
        check("trained_pred_target", pred_target, 32'h140);

        // Jump with the entry at 11: table must stay unchanged (verified after untraining).
        ex_valid = 1'b1; ex_jump = 1'b1; ex_pcsrc = 1'b1; ex_pred_taken = 1'b0;
        ex_pc = 32'h100; ex_target = 32'h80;
        cycle();
        ex_idle();
        check("jump_redirect", {31'd0, redirect}, 32'd1);
        check("jump_redirect_pc", redirect_pc, 32'h80);

        train(32'h100, 1'b0, 2);
        #1;
        check("untrained_pred_taken", {31'd0, pred_taken}, 32'd0);
        check("untrained_pred_target", pred_target, 32'h104);

        // Mispredict: predicted taken, resolved not-taken.
        ex_valid = 1'b1; ex_branch = 1'b1; ex_pc = 32'h200; ex_pcsrc = 1'b0; ex_pred_taken = 1'b1;
        cycle();
        ex_idle();
        check("mis_redirect", {31'd0, redirect}, 32'd1);
        check("mis_flush", {31'd0, flush}, 32'd1);
        check("mis_redirect_pc", redirect_pc, 32'h204);
        cycle();
        check("mis_redirect_pulse", {31'd0, redirect}, 32'd0);
        check("mis_flush_pulse", {31'd0, flush}, 32'd0);

        // Saturation at index 0 (entry now 00): five taken -> 3, not 1 by wrap.
        f_pc = 32'h300; f_target = 32'h3F0;
        train(32'h300, 1'b1, 5);
        #1;
        check("sat_pred_taken", {31'd0, pred_taken}, 32'd1);
        train(32'h300, 1'b0, 1);
        check("sat_after_dec", {31'd0, pred_taken}, 32'd1);
        // Same-index train and predict: prediction sees the old counter (2).
        ex_valid = 1'b1; ex_branch = 1'b1; ex_pc = 32'h300; ex_pcsrc = 1'b0; ex_pred_taken = 1'b0;
        #1;
        check("same_cycle_old_value", {31'd0, pred_taken}, 32'd1);
        cycle();
        ex_idle();
        check("same_cycle_after", {31'd0, pred_taken}, 32'd0);

        // tbl_clear after training index 33 to strongly taken.
        train(32'h84, 1'b1, 2);
        tbl_clear = 1'b1;
        cycle();
        tbl_clear = 1'b0;
        sweep_and_check("clr");

        // Reset mid-RUN while a mispredict is about to register.
        train(32'h84, 1'b1, 2);
        ex_valid = 1'b1; ex_branch = 1'b1; ex_pc = 32'h200; ex_pcsrc = 1'b0; ex_pred_taken = 1'b1;
        @(negedge clk);
        do_reset(2);
        ex_idle();
        check("midrst_redirect", {31'd0, redirect}, 32'd0);
        check("midrst_init_done", {31'd0, init_done}, 32'd0);
        sweep_and_check("rst");

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            f_valid       = ($urandom % 4) != 0;
            f_is_branch   = $urandom % 2;
            f_pc          = (($urandom % 16) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'h0000_01FC);
            f_target      = $urandom;
            ex_valid      = ($urandom % 4) != 0;
            ex_branch     = $urandom % 2;
            ex_jump       = ($urandom % 6) == 0;
            ex_pcsrc      = $urandom % 2;
            ex_pred_taken = $urandom % 2;
            ex_pc         = (($urandom % 16) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'h0000_01FC);
            ex_target     = $urandom;
            tbl_clear     = ($urandom % 300) == 0;
            if (($urandom % 1000) == 0) begin
                @(negedge clk);
                do_reset(2);
            end else begin
                cycle();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
